// File: rtl/life_keypad_pkg.sv
// Shared key-code and button-index constants for the life keypad, cursor and counter logic.
package life_keypad_pkg;

  localparam int NUM_KEYS = 7;
  localparam int NUM_DIR  = 4;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FLIP  = 4;
  localparam int BTN_RUN   = 5;
  localparam int BTN_STEP  = 6;

  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_UP    = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_LEFT  = 3'd3;
  localparam logic [2:0] KEY_RIGHT = 3'd4;
  localparam logic [2:0] KEY_FLIP  = 3'd5;
  localparam logic [2:0] KEY_RUN   = 3'd6;
  localparam logic [2:0] KEY_STEP  = 3'd7;

  // Button index i is reported on the keys bus as code i+1.
  function automatic logic [2:0] key_code(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/life_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw push-button.
module life_debounce #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter int          DEB_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic stable
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 16'd1);

  logic             s1;
  logic             s;
  logic [DEB_W-1:0] cnt;

  // Any sample that agrees with the debounced state restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s      <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= btn;
      s  <= s1;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/life_keypad.sv
// Debounced seven-button front-end producing single-cycle key codes for life.
// Optional direction-key auto-repeat is built when LIFE_KEY_REPEAT_EN is defined.
module life_keypad
  import life_keypad_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES    = 16'd50000,
  parameter int          DEB_W         = 16,
  parameter logic [23:0] REPEAT_DELAY  = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] btn,
  output logic [2:0] keys
);

  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] stable_d;
  logic [NUM_KEYS-1:0] pend;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rpt_set;
  logic [NUM_KEYS-1:0] grant;
  logic [2:0]          code;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
    life_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .DEB_W     (DEB_W)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[i]),
      .stable(stable[i])
    );
  end

  assign press = stable & ~stable_d;

  // Scan downward so the lowest pending index wins.
  always_comb begin
    grant = '0;
    code  = KEY_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        grant = NUM_KEYS'(1) << i;
        code  = key_code(3'(i));
      end
    end
  end

  // New events are ORed in after the grant clear, so a same-cycle set survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d <= '0;
      pend     <= '0;
      keys     <= KEY_NONE;
    end else begin
      stable_d <= stable;
      pend     <= (pend & ~grant) | press | rpt_set;
      keys     <= code;
    end
  end

`ifdef LIFE_KEY_REPEAT_EN
  logic        trk_valid;
  logic [1:0]  trk_idx;
  logic        trk_valid_q;
  logic [1:0]  trk_idx_q;
  logic [23:0] rpt_cnt;
  logic        rpt_phase;
  logic [23:0] rpt_limit;
  logic        trk_changed;
  logic        rpt_fire;

  always_comb begin
    trk_valid = 1'b0;
    trk_idx   = 2'd0;
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (stable[i]) begin
        trk_valid = 1'b1;
        trk_idx   = 2'(i);
      end
    end
  end

  assign trk_changed = (trk_valid != trk_valid_q) || (trk_idx != trk_idx_q);
  assign rpt_limit   = rpt_phase ? (REPEAT_PERIOD - 24'd1) : (REPEAT_DELAY - 24'd1);
  assign rpt_fire    = trk_valid && !trk_changed && (rpt_cnt == rpt_limit);
  assign rpt_set     = rpt_fire ? (NUM_KEYS'(1) << trk_idx) : '0;

  // The first interval after a (re)track is the delay, every later one the period.
  always_ff @(posedge clk) begin
    if (reset) begin
      trk_valid_q <= 1'b0;
      trk_idx_q   <= 2'd0;
      rpt_cnt     <= '0;
      rpt_phase   <= 1'b0;
    end else begin
      trk_valid_q <= trk_valid;
      trk_idx_q   <= trk_idx;
      if (!trk_valid || trk_changed) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 24'd1;
      end
    end
  end
`else
  assign rpt_set = '0;

  if (REPEAT_DELAY == 24'd0 || REPEAT_PERIOD == 24'd0) begin : g_repeat_cfg_unused
  end
`endif

endmodule

// File: tb/tb_life_keypad.sv
// Randomised and directed bench for life_keypad with DEB_CYCLES=4 against a behavioural key model.
module tb_life_keypad;

  localparam int DEB   = 4;
  localparam int R_DEL = 20;
  localparam int R_PER = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] btn;
  logic [2:0] keys;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected outputs: {edge number, key code}.
  logic [34:0] exp_q[$];
  logic [34:0] mon_e;
  int          seen_cyc[8];

  // Behavioural model state.
  logic [6:0] m_s1, m_s, m_stable, m_stable_prev, m_pend;
  int         m_run[7];
  int         m_trk_prev  = -1;
  int         m_trk_start = 0;

  life_keypad #(
    .DEB_CYCLES   (16'(DEB)),
    .DEB_W        (16),
    .REPEAT_DELAY (24'(R_DEL)),
    .REPEAT_PERIOD(24'(R_PER))
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .keys (keys)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = '0; m_s = '0; m_stable = '0; m_stable_prev = '0; m_pend = '0;
    for (int i = 0; i < 7; i++) m_run[i] = 0;
    m_trk_prev = -1;
  endtask

  // One clock edge: emit the lowest pending key, record new events, then age the button history.
  task automatic model_step();
    logic [6:0] ev;
    int         code;
    int         trk;
    int         d;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    ev = m_stable & ~m_stable_prev;
    trk = -1;
    for (int i = 3; i >= 0; i--) if (m_stable[i]) trk = i;
    if (trk != m_trk_prev) m_trk_start = cyc;
    m_trk_prev = trk;
`ifdef LIFE_KEY_REPEAT_EN
    if (trk >= 0) begin
      d = cyc - m_trk_start;
      if (d == R_DEL || (d > R_DEL && ((d - R_DEL) % R_PER) == 0)) ev[trk] = 1'b1;
    end
`else
    d = 0;
`endif
    code = 0;
    for (int i = 0; i < 7; i++) begin
      if (m_pend[i] && code == 0) begin
        code = i + 1;
        m_pend[i] = 1'b0;
      end
    end
    if (code != 0) exp_q.push_back({32'(cyc), 3'(code)});
    m_pend = m_pend | ev;
    m_stable_prev = m_stable;
    for (int i = 0; i < 7; i++) begin
      if (m_s[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_stable[i] = ~m_stable[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s  = m_s1;
    m_s1 = btn;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: any nonzero code, or an expected code due this edge, is checked against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (keys != 3'd0 || (exp_q.size() != 0 && exp_q[0][34:3] == 32'(cyc))) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_key edge=%0d got=%0d want=none", cyc, keys);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e != {32'(cyc), keys}) begin
            errors++;
            $display("FAIL key_event got edge=%0d code=%0d want edge=%0d code=%0d",
                     cyc, keys, mon_e[34:3], mon_e[2:0]);
          end
        end
        if (keys != 3'd0) seen_cyc[keys] = cyc;
      end
    end
  end

  task automatic drive(input logic [6:0] v, input int n);
    btn = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 8; i++) seen_cyc[i] = -1;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    int e_edge;
    int budget;
    reset = 1'b1;
    btn   = '0;
    clear_seen();

    repeat (3) begin
      @(negedge clk);
      check_int("reset_keys", int'(keys), 0);
    end
    reset = 1'b0;
    drive('0, 20);
    check_int("idle_keys", int'(keys), 0);

    // Clean press of UP.
    clear_seen();
    e_edge = cyc + 1;
    drive(7'b0000001, 15);
    drive('0, 15);
    check_int("clean_press_time", seen_cyc[1], e_edge + 3 + DEB);

    // Bouncy FLIP, then a lone short glitch on LEFT.
    clear_seen();
    drive(7'b0010000, 2); drive('0, 2);
    drive(7'b0010000, 2); drive('0, 2);
    e_edge = cyc + 1;
    drive(7'b0010000, 15);
    drive('0, 15);
    check_int("bounce_press_time", seen_cyc[5], e_edge + 3 + DEB);
    drive(7'b0000100, 3);
    drive('0, 15);
    check_int("glitch_no_event", seen_cyc[3], -1);

    // Simultaneous DOWN, FLIP, STEP.
    clear_seen();
    e_edge = cyc + 1;
    drive(7'b1010010, 15);
    drive('0, 15);
    check_int("simul_first", seen_cyc[2], e_edge + 3 + DEB);
    check_int("simul_second", seen_cyc[5], e_edge + 4 + DEB);
    check_int("simul_third", seen_cyc[7], e_edge + 5 + DEB);

    // Long RIGHT hold (repeats when enabled), then RUN which never repeats.
    drive(7'b0001000, 60);
    drive('0, 15);
    drive(7'b0100000, 40);
    drive('0, 15);

    // Reset while three events are pending discards them.
    btn = 7'b0000111;
    budget = 40;
    while (m_pend != 7'b0000111 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_int("pend_reached", int'(budget > 0), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(7'b0000111, 20);
    drive('0, 15);

    // Random button patterns and hold lengths.
    for (int k = 0; k < 150; k++) begin
      drive(7'($urandom_range(0, 127)), $urandom_range(1, 12));
    end
    drive('0, 40);

    check_int("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
